// File: rtl/spike_packet_dispatcher.sv
// spike_packet_dispatcher: buffers 24-bit spike packets in a small FIFO, resolves
// each packet's destination against a loadable neuron address table and delivers
// the origin as a one-cycle strobe to the lowest-indexed matching neuron slot.
module spike_packet_dispatcher #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          CLK,
    input  logic                          clear,
    input  logic                          pkt_valid,
    output logic                          pkt_ready,
    input  logic [2*ADDR_W-1:0]           packet,
    input  logic                          init_load,
    input  logic [NUM_NEURONS*ADDR_W-1:0] neuron_addresses_initialization,
    output logic [NUM_NEURONS*ADDR_W-1:0] source_address,
    output logic [NUM_NEURONS-1:0]        deliver_valid,
    output logic [7:0]                    drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PKT_W = 2 * ADDR_W;

    // Packet buffer and its bookkeeping
    logic [PKT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    // Lookup register L
    logic              l_valid_reg;
    logic [PKT_W-1:0]  l_pkt_reg;

    // Neuron address table
    logic [ADDR_W-1:0]      table_addr_reg [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] table_valid_reg;

    // Delivery registers
    logic [ADDR_W-1:0]      src_reg [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] deliver_reg;
    logic [7:0]             drop_reg;

    logic                   push;
    logic                   pop;
    logic                   resolve;
    logic [ADDR_W-1:0]      l_dest;
    logic [ADDR_W-1:0]      l_origin;
    logic [NUM_NEURONS-1:0] match;
    logic [NUM_NEURONS-1:0] sel_next;
    logic                   any_match;

    // Ready comes only from registered occupancy, so a full FIFO never accepts even on a pop
    assign pkt_ready = (count_reg != CNT_W'(FIFO_DEPTH));
    assign push      = pkt_valid && pkt_ready;
    assign pop       = (count_reg != '0) && !init_load;
    // A table load freezes the pipeline: the held L entry is resolved once the load ends
    assign resolve   = l_valid_reg && !init_load;
    assign l_origin  = l_pkt_reg[PKT_W-1:ADDR_W];
    assign l_dest    = l_pkt_reg[ADDR_W-1:0];
    assign any_match = |match;

    assign fifo_count    = count_reg;
    assign deliver_valid = deliver_reg;
    assign drop_count    = drop_reg;

    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_slot
            assign match[gi] = table_valid_reg[gi] && (table_addr_reg[gi] == l_dest);
            assign source_address[gi*ADDR_W +: ADDR_W] = src_reg[gi];
        end
    endgenerate

    // FIFO storage write (no reset so it can map onto RAM)
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= packet;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth makes pointers wrap naturally
    always_ff @(posedge CLK) begin
        if (!clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Lookup register data: registered read of the FIFO head
    always_ff @(posedge CLK) begin
        if (pop) begin
            l_pkt_reg <= fifo_mem[rd_ptr_reg];
        end
    end

    // Lookup register valid: holds during a table load, otherwise follows the pop
    always_ff @(posedge CLK) begin
        if (!clear) begin
            l_valid_reg <= 1'b0;
        end else if (!init_load) begin
            l_valid_reg <= pop;
        end
    end

    // Table addresses are don't-care after reset, only the valid bits are cleared
    always_ff @(posedge CLK) begin
        if (init_load) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                table_addr_reg[i] <= neuron_addresses_initialization[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Table valid bits
    always_ff @(posedge CLK) begin
        if (!clear) begin
            table_valid_reg <= '0;
        end else if (init_load) begin
            table_valid_reg <= '1;
        end
    end

    // Priority select: lowest matching slot wins when several share an address
    always_comb begin
        sel_next = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_next = '0;
                sel_next[i] = 1'b1;
            end
        end
    end

    // Delivery: strobe the selected slot and latch the origin, or count a drop
    always_ff @(posedge CLK) begin
        if (!clear) begin
            deliver_reg <= '0;
            drop_reg    <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                src_reg[i] <= '0;
            end
        end else begin
            deliver_reg <= resolve ? sel_next : '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (resolve && sel_next[i]) begin
                    src_reg[i] <= l_origin;
                end
            end
            if (resolve && !any_match && (drop_reg != 8'hFF)) begin
                drop_reg <= drop_reg + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spike_packet_dispatcher.sv
// Directed testbench for spike_packet_dispatcher with hand-computed expectations.
module tb_spike_packet_dispatcher;

    localparam int NUM_NEURONS = 10;
    localparam int ADDR_W      = 12;
    localparam int FIFO_DEPTH  = 8;

    logic                          CLK;
    logic                          clear;
    logic                          pkt_valid;
    logic                          pkt_ready;
    logic [2*ADDR_W-1:0]           packet;
    logic                          init_load;
    logic [NUM_NEURONS*ADDR_W-1:0] neuron_addresses_initialization;
    logic [NUM_NEURONS*ADDR_W-1:0] source_address;
    logic [NUM_NEURONS-1:0]        deliver_valid;
    logic [7:0]                    drop_count;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    int errors = 0;
    int checks = 0;

    spike_packet_dispatcher #(
        .NUM_NEURONS(NUM_NEURONS),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK                            (CLK),
        .clear                          (clear),
        .pkt_valid                      (pkt_valid),
        .pkt_ready                      (pkt_ready),
        .packet                         (packet),
        .init_load                      (init_load),
        .neuron_addresses_initialization(neuron_addresses_initialization),
        .source_address                 (source_address),
        .deliver_valid                  (deliver_valid),
        .drop_count                     (drop_count),
        .fifo_count                     (fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] slot(input int k);
        return source_address[k*ADDR_W +: ADDR_W];
    endfunction

    // Table image: slot k = 0x100+k, optionally slots 2 and 7 both = 0x050
    function automatic logic [NUM_NEURONS*ADDR_W-1:0] table_image(input bit dup);
        logic [NUM_NEURONS*ADDR_W-1:0] img;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            img[k*ADDR_W +: ADDR_W] = ADDR_W'(12'h100 + k);
        end
        if (dup) begin
            img[2*ADDR_W +: ADDR_W] = 12'h050;
            img[7*ADDR_W +: ADDR_W] = 12'h050;
        end
        return img;
    endfunction

    task automatic load_table(input bit dup);
        neuron_addresses_initialization = table_image(dup);
        init_load = 1'b1;
        tick();
        init_load = 1'b0;
    endtask

    initial begin
        int accepted;
        logic [NUM_NEURONS*ADDR_W-1:0] zero_bus;
        zero_bus = '0;

        clear     = 1'b0;
        pkt_valid = 1'b0;
        packet    = '0;
        init_load = 1'b0;
        neuron_addresses_initialization = '0;
        tick();
        tick();
        clear = 1'b1;

        // Reset state
        check_eq("rst_deliver", 128'(deliver_valid), 128'(0));
        check_eq("rst_src", 128'(source_address), 128'(0));
        check_eq("rst_drop", 128'(drop_count), 128'(0));
        check_eq("rst_count", 128'(fifo_count), 128'(0));
        check_eq("rst_ready", 128'(pkt_ready), 128'(1));

        load_table(1'b0);

        // Basic delivery: 0x00A_105 reaches slot 5 two edges after acceptance
        pkt_valid = 1'b1;
        packet    = 24'h00A105;
        tick();
        pkt_valid = 1'b0;
        check_eq("basic_count_e0", 128'(fifo_count), 128'(1));
        tick();
        check_eq("basic_deliver_e1", 128'(deliver_valid), 128'(0));
        tick();
        check_eq("basic_deliver_e2", 128'(deliver_valid), 128'(10'b0000100000));
        check_eq("basic_slot5", 128'(slot(5)), 128'(12'h00A));
        check_eq("basic_drop", 128'(drop_count), 128'(0));
        tick();
        check_eq("basic_one_cycle", 128'(deliver_valid), 128'(0));

        // Miss: unmatched destination increments drop_count
        pkt_valid = 1'b1;
        packet    = 24'h0031FF;
        tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        check_eq("miss_deliver", 128'(deliver_valid), 128'(0));
        check_eq("miss_drop1", 128'(drop_count), 128'(1));

        // 300 more misses saturate the drop counter
        pkt_valid = 1'b1;
        packet    = 24'h0031FF;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        pkt_valid = 1'b0;
        tick();
        tick();
        tick();
        check_eq("miss_saturate", 128'(drop_count), 128'(255));
        check_eq("miss_no_strobe", 128'(deliver_valid), 128'(0));

        // Back-pressure: table load held, 10 offered, only 8 fit
        neuron_addresses_initialization = table_image(1'b0);
        init_load = 1'b1;
        pkt_valid = 1'b1;
        accepted  = 0;
        for (int i = 0; i < 10; i++) begin
            packet = {ADDR_W'(12'h200 + accepted), ADDR_W'(12'h100 + accepted)};
            if (pkt_ready) accepted++;
            tick();
            check_eq("bp_no_strobe", 128'(deliver_valid), 128'(0));
        end
        pkt_valid = 1'b0;
        check_eq("bp_accepted", 128'(accepted), 128'(8));
        check_eq("bp_count", 128'(fifo_count), 128'(8));
        check_eq("bp_ready", 128'(pkt_ready), 128'(0));
        init_load = 1'b0;
        tick();
        check_eq("bp_first_pop", 128'(deliver_valid), 128'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("bp_order", 128'(deliver_valid), 128'(10'b1 << i));
            check_eq("bp_origin", 128'(slot(i)), 128'(12'h200 + i));
        end
        tick();
        check_eq("bp_drained_strobe", 128'(deliver_valid), 128'(0));
        check_eq("bp_drained_count", 128'(fifo_count), 128'(0));

        // Duplicate address: slots 2 and 7 share 0x050, lowest wins
        load_table(1'b1);
        pkt_valid = 1'b1;
        packet    = 24'h001050;
        tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        check_eq("dup_deliver", 128'(deliver_valid), 128'(10'b0000000100));
        check_eq("dup_slot2", 128'(slot(2)), 128'(12'h001));
        check_eq("dup_slot7_kept", 128'(slot(7)), 128'(12'h207));

        // Streaming: 20 back-to-back packets, one strobe per cycle
        load_table(1'b0);
        for (int s = 0; s < 22; s++) begin
            if (s < 20) begin
                pkt_valid = 1'b1;
                packet    = {ADDR_W'(12'h300 + s), ADDR_W'(12'h100 + (s % 10))};
            end else begin
                pkt_valid = 1'b0;
            end
            tick();
            check_eq("stream_count", 128'(fifo_count), 128'((s < 20) ? 1 : 0));
            if (s >= 2) begin
                check_eq("stream_deliver", 128'(deliver_valid), 128'(10'b1 << ((s - 2) % 10)));
                check_eq("stream_origin", 128'(slot((s - 2) % 10)), 128'(12'h300 + s - 2));
            end
        end
        pkt_valid = 1'b0;

        // Reset mid-stream: 3 queued plus 1 in L, all discarded
        init_load = 1'b1;
        pkt_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            packet = {ADDR_W'(12'h400 + i), ADDR_W'(12'h101 + i)};
            tick();
        end
        pkt_valid = 1'b0;
        init_load = 1'b0;
        tick();
        check_eq("mid_count_before", 128'(fifo_count), 128'(3));
        check_eq("mid_deliver_before", 128'(deliver_valid), 128'(0));
        clear = 1'b0;
        tick();
        clear = 1'b1;
        check_eq("mid_count", 128'(fifo_count), 128'(0));
        check_eq("mid_src", 128'(source_address), 128'(zero_bus));
        check_eq("mid_ready", 128'(pkt_ready), 128'(1));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("mid_no_strobe", 128'(deliver_valid), 128'(0));
        end
        check_eq("mid_src_after", 128'(source_address), 128'(zero_bus));
        check_eq("mid_count_after", 128'(fifo_count), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_packet_dispatcher.md
# spike_packet_dispatcher

Receives the 24-bit spike packets emitted by the network interface, buffers them in a small FIFO, and resolves each packet's destination against a neuron address table. Each resolved packet is delivered as a one-cycle source-address strobe to exactly one neuron slot of the accelerator array. This block is the consumer stage between `network_interface` and the per-neuron `source_address` inputs. It replaces the current combinational write from packet to neuron with a buffered, back-pressured, registered path.

## Interface

Parameters:
- `NUM_NEURONS`, 10: neuron slots served.
- `ADDR_W`, 12: neuron/source address width; packet width is 2*ADDR_W.
- `FIFO_DEPTH`, 8: packet buffer entries; power of two, at least 2.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `clear`, in, 1: reset, synchronous and active-low; `clear`==0 at a rising edge resets the block.
- `pkt_valid`, in, 1: `packet` is valid.
- `pkt_ready`, out, 1: the block can accept a packet this cycle.
- `packet`, in, 2*ADDR_W: [23:12] is the origin (spiking neuron address); [11:0] is the destination neuron address.
- `init_load`, in, 1: load the address table from `neuron_addresses_initialization`.
- `neuron_addresses_initialization`, in, NUM_NEURONS*ADDR_W: slot k is bits [12k+11:12k].
- `source_address`, out, NUM_NEURONS*ADDR_W: per-slot delivered origin, laid out the same way.
- `deliver_valid`, out, NUM_NEURONS: one-hot strobe; bit k high means slot k holds a new origin this cycle.
- `drop_count`, out, 8: count of packets that matched no slot; saturates.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation

- **Reset** (`clear`==0): FIFO emptied with pointers at 0. Lookup register invalid. Table valid bits cleared; table address contents don't-care. `source_address` set to all zeros. `deliver_valid` set to 0. `drop_count` set to 0. `fifo_count` set to 0. `pkt_ready` reads 1 in the first cycle after reset. Reset mid-operation discards all buffered and in-flight packets with no delivery.
- **Table load**: when `init_load`==1 at an edge, every table entry is written from the bus and every valid bit is set.
  - While `init_load`==1 the pipeline is frozen: no FIFO pop, the lookup register holds, and `deliver_valid` is 0.
  - FIFO pushes continue during a load.
- **Stage 0, FIFO push**: on `pkt_valid && pkt_ready`.
  - `pkt_ready` = (`fifo_count` != FIFO_DEPTH).
  - `pkt_ready` does not depend on a same-cycle pop, so a full FIFO never accepts.
  - Pointers wrap modulo FIFO_DEPTH. There is no bypass path.
- **Stage 1, pop**: when the FIFO is not empty and `init_load`==0, the head is moved into the lookup register L and L is marked valid. Otherwise L becomes invalid.
- **Stage 2, resolve and deliver**: when L is valid, its destination is compared against all valid table entries.
  - On one or more matches, the lowest matching index k is selected: `source_address[k]` is set to L.origin, `deliver_valid` is set to one-hot(k), and all other slots keep their previous `source_address`.
  - On no match, `deliver_valid` is 0 and `drop_count` increments, saturating at 255.
- `deliver_valid` is high for exactly one cycle per resolved packet.
- A simultaneous push and pop leaves `fifo_count` unchanged.

## Timing

- Push accepted at edge E0. Pop into L at E1. `deliver_valid` and `source_address` registered at E2.
  - Latency is 2 cycles from the accepting edge to the delivery edge when the FIFO and pipeline are empty.
- Sustained throughput is one packet per cycle. The FIFO never fills unless `init_load` is held.
- `fifo_count` and `pkt_ready` update one cycle after the push or pop edge.
- A `drop_count` increment is visible after E2.
- `init_load` asserted for N cycles delays every queued packet by N cycles; no packet is lost.
- All outputs are registered except `pkt_ready`, which is decoded from the registered `fifo_count`.

## Test plan

- **Basic delivery**: reset, load table slots 0..9 = 0x100..0x109, push 0x00A_105 once.
  - Required: at the 2nd edge after acceptance, `deliver_valid`=10'b0000100000 for one cycle and slot 5 `source_address`=0x00A. `drop_count`=0.
- **Miss**: push 0x003_1FF.
  - Required: `deliver_valid` stays 0 and `drop_count`=1. Then 300 misses give `drop_count`=255.
- **Back-pressure and wrap**: hold `init_load`=1 and push 10 packets with `pkt_valid` held high.
  - Required: exactly 8 accepted, `pkt_ready`=0 at `fifo_count`=8. After `init_load` drops, 8 strobes are delivered in order over 8 consecutive cycles, with pointers wrapped.
- **Duplicate address**: load slots 2 and 7 = 0x050, push 0x001_050.
  - Required: only bit 2 strobes.
- **Streaming**: 20 back-to-back packets to rotating slots.
  - Required: one strobe per cycle and `fifo_count` never above 1.
- **Reset mid-stream**: assert `clear`=0 with 3 packets queued and 1 in L.
  - Required: no further strobes, `fifo_count`=0, and all `source_address` equal to 0.
